// File: rtl/window_shift_buffer_pkg.sv
// Shared defaults and indexing helper for the sliding-window shift buffer.
// Element order of the flat window bus is slot-major, then column (0 oldest), then row.
package window_shift_buffer_pkg;

    localparam int DEF_IO_DATA_WIDTH = 16;
    localparam int DEF_KERNEL_SIZE   = 3;
    localparam int DEF_NB_SLOTS      = 4;

    function automatic int elem_idx(input int s, input int c, input int r, input int k);
        return (s * k + c) * k + r;
    endfunction

endpackage

// File: rtl/window_shift_buffer_if.sv
// Column-load and window-output handshake bundle for window_shift_buffer.
// master = producer/consumer side, slave = the buffer itself.
interface window_shift_buffer_if
    import window_shift_buffer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int NB_SLOTS      = DEF_NB_SLOTS
);
    localparam int SW = (NB_SLOTS > 1) ? $clog2(NB_SLOTS) : 1;

    logic [KERNEL_SIZE*IO_DATA_WIDTH-1:0]                      col_in;
    logic [SW-1:0]                                             col_slot;
    logic                                                      col_valid;
    logic                                                      col_ready;
    logic                                                      clear;
    logic [NB_SLOTS*KERNEL_SIZE*KERNEL_SIZE*IO_DATA_WIDTH-1:0] win_out;
    logic                                                      win_valid;
    logic                                                      win_ready;
    logic [NB_SLOTS-1:0]                                       slot_full;

    modport master (
        output col_in, col_slot, col_valid, clear, win_ready,
        input  col_ready, win_out, win_valid, slot_full
    );

    modport slave (
        input  col_in, col_slot, col_valid, clear, win_ready,
        output col_ready, win_out, win_valid, slot_full
    );

endinterface

// File: rtl/wsb_slot.sv
// One KxK window: column shift register (column K-1 newest) plus saturating fill counter.
// Data is never touched by clear or consume; only the fill level moves.
module wsb_slot
    import window_shift_buffer_pkg::*;
#(
    parameter int W = DEF_IO_DATA_WIDTH,
    parameter int K = DEF_KERNEL_SIZE
) (
    input  logic             clk,
    input  logic             rst_in,
    input  logic             load,
    input  logic             consume,
    input  logic             clear,
    input  logic [K*W-1:0]   col_in,
    output logic [K*K*W-1:0] win,
    output logic             full
);
    localparam int FW = $clog2(K + 1);

    logic [FW-1:0] fill;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            win  <= '0;
            fill <= '0;
        end else begin
            if (load && !clear)
                win <= {col_in, win[K*K*W-1:K*W]};
            if (clear)
                fill <= '0;
            else if (consume)
                // a same-cycle load completes the slid window immediately
                fill <= load ? FW'(K) : FW'(K - 1);
            else if (load && fill != FW'(K))
                fill <= fill + 1'b1;
        end
    end

    assign full = (fill == FW'(K));

endmodule

// File: rtl/window_shift_buffer.sv
// NB_SLOTS independent KxK sliding windows loaded column-wise, presented together to the MAC array.
// WINDOW_SHIFT_BUFFER_PASSTHRU_EN: allow a column into a full slot in the consume cycle (no bubble).
module window_shift_buffer
    import window_shift_buffer_pkg::*;
#(
    parameter int IO_DATA_WIDTH = DEF_IO_DATA_WIDTH,
    parameter int KERNEL_SIZE   = DEF_KERNEL_SIZE,
    parameter int NB_SLOTS      = DEF_NB_SLOTS
) (
    input logic                clk,
    input logic                rst_in,
    window_shift_buffer_if.slave bus
);
    localparam int W  = IO_DATA_WIDTH;
    localparam int K  = KERNEL_SIZE;
    localparam int N  = NB_SLOTS;
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    logic [N*K*K*W-1:0] wins;
    logic [N-1:0]       full_vec;
    logic [N-1:0]       load;
    logic               hit;
    logic               sel_full;
    logic               consume;
    logic               accept;

    always_comb begin
        hit      = 1'b0;
        sel_full = 1'b0;
        for (int s = 0; s < N; s++) begin
            if (bus.col_slot == SW'(s)) begin
                hit      = 1'b1;
                sel_full = full_vec[s];
            end
        end
    end

    assign bus.win_valid = &full_vec;
    assign consume       = bus.win_valid && bus.win_ready && !bus.clear;

`ifdef WINDOW_SHIFT_BUFFER_PASSTHRU_EN
    assign bus.col_ready = !bus.clear && hit && (!sel_full || consume);
`else
    assign bus.col_ready = !bus.clear && hit && !sel_full;
`endif

    assign accept = bus.col_valid && bus.col_ready;

    always_comb begin
        load = '0;
        for (int s = 0; s < N; s++)
            load[s] = accept && (bus.col_slot == SW'(s));
    end

    for (genvar s = 0; s < N; s++) begin : g_slot
        wsb_slot #(.W(W), .K(K)) u_slot (
            .clk     (clk),
            .rst_in  (rst_in),
            .load    (load[s]),
            .consume (consume),
            .clear   (bus.clear),
            .col_in  (bus.col_in),
            .win     (wins[s*K*K*W +: K*K*W]),
            .full    (full_vec[s])
        );
    end

    assign bus.win_out   = wins;
    assign bus.slot_full = full_vec;

endmodule

// File: tb/tb_window_shift_buffer.sv
// Randomized self-checking bench for window_shift_buffer against an array-based window model.
// A second NB_SLOTS=3 instance covers the out-of-range slot select.
module tb_window_shift_buffer;
    localparam int W   = 16;
    localparam int K   = 3;
    localparam int N   = 4;
    localparam int N3  = 3;
    localparam int TOT = N * K * K * W;
`ifdef WINDOW_SHIFT_BUFFER_PASSTHRU_EN
    localparam bit PT = 1'b1;
`else
    localparam bit PT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_in = 1'b1;
    always #5 clk = ~clk;

    window_shift_buffer_if #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_SLOTS(N))  bus  ();
    window_shift_buffer_if #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_SLOTS(N3)) bus3 ();

    window_shift_buffer #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_SLOTS(N)) dut (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus)
    );

    window_shift_buffer #(.IO_DATA_WIDTH(W), .KERNEL_SIZE(K), .NB_SLOTS(N3)) dut3 (
        .clk    (clk),
        .rst_in (rst_in),
        .bus    (bus3)
    );

    int n_chk = 0;
    int n_bad = 0;

    logic [W-1:0] m_win [N][K][K];
    int           m_fill [N];

    task automatic chk(input string tag, input logic [TOT-1:0] got, input logic [TOT-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < N; s++) begin
            m_fill[s] = 0;
            for (int c = 0; c < K; c++)
                for (int r = 0; r < K; r++)
                    m_win[s][c][r] = '0;
        end
    endtask

    function automatic logic [TOT-1:0] exp_win();
        logic [TOT-1:0] v = '0;
        for (int s = 0; s < N; s++)
            for (int c = 0; c < K; c++)
                for (int r = 0; r < K; r++)
                    v[((s*K+c)*K+r)*W +: W] = m_win[s][c][r];
        return v;
    endfunction

    function automatic logic [K*W-1:0] mk_col(input int base, input bit per_row);
        logic [K*W-1:0] v = '0;
        for (int r = 0; r < K; r++)
            v[r*W +: W] = W'(base + (per_row ? r : 0));
        return v;
    endfunction

    task automatic do_reset();
        rst_in        = 1'b1;
        bus.col_valid = 1'b0;
        bus.clear     = 1'b0;
        bus.win_ready = 1'b0;
        bus.col_slot  = '0;
        bus.col_in    = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_in = 1'b0;
        model_reset();
    endtask

    task automatic do_cycle(input bit valid, input int slot, input logic [K*W-1:0] data,
                            input bit clr, input bit wrdy);
        bit           all_full;
        bit           consume;
        bit           exp_rdy;
        logic [N-1:0] exp_full;
        bus.col_valid = valid;
        bus.col_slot  = slot[1:0];
        bus.col_in    = data;
        bus.clear     = clr;
        bus.win_ready = wrdy;
        #1;
        all_full = 1'b1;
        for (int s = 0; s < N; s++) begin
            exp_full[s] = (m_fill[s] == K);
            if (m_fill[s] != K) all_full = 1'b0;
        end
        consume = all_full && wrdy && !clr;
        exp_rdy = !clr && slot < N && (m_fill[slot] != K || (PT && consume));
        chk("col_ready", TOT'(bus.col_ready), TOT'(exp_rdy));
        chk("win_valid", TOT'(bus.win_valid), TOT'(all_full));
        chk("slot_full", TOT'(bus.slot_full), TOT'(exp_full));
        chk("win_out", bus.win_out, exp_win());
        if (clr) begin
            for (int s = 0; s < N; s++) m_fill[s] = 0;
        end else begin
            if (consume)
                for (int s = 0; s < N; s++) m_fill[s] = K - 1;
            if (valid && exp_rdy) begin
                for (int c = 0; c < K - 1; c++)
                    for (int r = 0; r < K; r++)
                        m_win[slot][c][r] = m_win[slot][c+1][r];
                for (int r = 0; r < K; r++)
                    m_win[slot][K-1][r] = data[r*W +: W];
                if (m_fill[slot] < K) m_fill[slot]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        do_cycle(1'b0, 0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        bus3.col_valid = 1'b0;
        bus3.col_slot  = '0;
        bus3.col_in    = '0;
        bus3.clear     = 1'b0;
        bus3.win_ready = 1'b0;
        do_reset();

        // reset values, col_slot=0 must be ready
        idle();

        // out-of-range slot on the 3-slot instance is never accepted
        bus3.col_valid = 1'b1;
        bus3.col_slot  = 2'd3;
        bus3.col_in    = mk_col(77, 1'b1);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("n3_oob_ready", TOT'(bus3.col_ready), TOT'(0));
            chk("n3_oob_full", TOT'(bus3.slot_full), TOT'(0));
            @(posedge clk);
            #1;
        end
        bus3.col_slot = 2'd2;
        #1;
        chk("n3_inrange_ready", TOT'(bus3.col_ready), TOT'(1));
        bus3.col_valid = 1'b0;

        // fill: value s*100+c*10+r
        for (int s = 0; s < N; s++)
            for (int c = 0; c < K; c++)
                do_cycle(1'b1, s, mk_col(s*100 + c*10, 1'b1), 1'b0, 1'b0);
        #1;
        chk("fill_valid", TOT'(bus.win_valid), TOT'(1));
        chk("fill_elem_321", TOT'(bus.win_out[((3*K+2)*K+1)*W +: W]), TOT'(321));
        chk("fill_elem_012", TOT'(bus.win_out[((0*K+1)*K+2)*W +: W]), TOT'(12));

        // backpressure on slot 2
        for (int i = 0; i < 10; i++)
            do_cycle(1'b1, 2, W*K'($urandom), 1'b0, 1'b0);

        // slide by one column per slot
        do_cycle(1'b0, 0, '0, 1'b0, 1'b1);
        for (int s = 0; s < N; s++)
            do_cycle(1'b1, s, mk_col(900 + s, 1'b0), 1'b0, 1'b0);
        #1;
        chk("slide_valid", TOT'(bus.win_valid), TOT'(1));
        chk("slide_c0", TOT'(bus.win_out[((1*K+0)*K+2)*W +: W]), TOT'(112));
        chk("slide_c1", TOT'(bus.win_out[((1*K+1)*K+0)*W +: W]), TOT'(120));
        chk("slide_c2", TOT'(bus.win_out[((1*K+2)*K+1)*W +: W]), TOT'(901));

        // clear mid-fill
        do_cycle(1'b0, 0, '0, 1'b1, 1'b0);
        do_cycle(1'b1, 1, mk_col(500, 1'b1), 1'b0, 1'b0);
        do_cycle(1'b1, 1, mk_col(510, 1'b1), 1'b0, 1'b0);
        do_cycle(1'b1, 1, mk_col(520, 1'b1), 1'b1, 1'b0);
        for (int c = 0; c < K; c++)
            do_cycle(1'b1, 1, mk_col(600 + c*10, 1'b1), 1'b0, 1'b0);
        #1;
        chk("clear_refill_full", TOT'(bus.slot_full), TOT'(4'b0010));

        // consume and offer a column in the same cycle
        for (int s = 0; s < N; s++)
            for (int c = 0; c < K; c++)
                do_cycle(1'b1, s, W*K'($urandom), 1'b0, 1'b0);
        #1;
        chk("pt_ready", TOT'(bus.col_ready), TOT'(0));
        bus.col_slot  = 2'd0;
        bus.win_ready = 1'b1;
        #1;
        chk("pt_same_cycle_ready", TOT'(bus.col_ready), TOT'(PT));
        do_cycle(1'b1, 0, mk_col(700, 1'b1), 1'b0, 1'b1);
        idle();

        // random traffic with occasional clear and reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
                idle();
            end else begin
                do_cycle($urandom_range(0, 3) != 0, int'($urandom_range(0, N - 1)),
                         W*K'($urandom) ^ (W*K'($urandom) << 16),
                         $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
